// File: rtl/pc_fetch_ctrl_pkg.sv
// ============================================================================
//  Module   : pc_fetch_ctrl_pkg
//  Brief    : Shared state encodings and reset PC for the fetch controller.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_fetch_ctrl_pkg;

    typedef logic [2:0] fsm_state_t;

    localparam fsm_state_t FSM_RESET_WAIT = 3'd0;
    localparam fsm_state_t FSM_FETCH      = 3'd1;
    localparam fsm_state_t FSM_ISSUE      = 3'd2;
    localparam fsm_state_t FSM_WAIT_NPC   = 3'd3;
    localparam fsm_state_t FSM_HALT       = 3'd4;

    // Word address 0x0C00 == byte address 0x0000_3000
    localparam logic [29:0] c_reset_pc_default = 30'h0000_0C00;

endpackage

`default_nettype wire

// File: rtl/pc_perf_counters.sv
// ============================================================================
//  Module   : pc_perf_counters
//  Brief    : Retired-instruction and fetch-stall counters (wrap at 2^32).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_perf_counters (
    input  logic        clk,
    input  logic        rst,
    input  logic        retire_inc,
    input  logic        stall_inc,
    output logic [31:0] retired_cnt,
    output logic [31:0] stall_cnt
);

    logic [31:0] r_retired_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired_cnt <= 32'd0;
            r_stall_cnt   <= 32'd0;
        end else begin
            if (retire_inc) r_retired_cnt <= r_retired_cnt + 32'd1;
            if (stall_inc)  r_stall_cnt   <= r_stall_cnt + 32'd1;
        end
    end

    assign retired_cnt = r_retired_cnt;
    assign stall_cnt   = r_stall_cnt;

endmodule

`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
// ============================================================================
//  Module   : pc_fetch_ctrl
//  Brief    : Fetch sequencer owning the architectural PC; fetch -> issue ->
//             wait for next-PC. Optional counters under PC_FETCH_CTRL_PERF_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [29:0] RESET_PC           = c_reset_pc_default,
    parameter bit          HALT_ON_ZERO_INSTR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [29:0] instr_pc,
    input  logic        npc_valid,
    input  logic [29:0] npc,
    input  logic        halt_req,
    output logic        halted,
    output logic [29:0] pc
`ifdef PC_FETCH_CTRL_PERF_EN
    ,
    output logic [31:0] retired_cnt,
    output logic [31:0] stall_cnt
`endif
);

    fsm_state_t  r_state;
    fsm_state_t  w_state_nxt;
    logic [29:0] r_pc;
    logic [31:0] r_instr;
    logic [29:0] r_instr_pc;
    logic        r_instr_valid;
    logic        r_halt_sticky;
    logic        w_fetch_ack;
    logic        w_npc_take;
    logic        w_zero_halt;

    assign w_fetch_ack = (r_state == FSM_FETCH) && imem_ack;
    assign w_npc_take  = (r_state == FSM_WAIT_NPC) && npc_valid;
    // A zero word fetched after a pending halt request stops before execution
    assign w_zero_halt = HALT_ON_ZERO_INSTR && r_halt_sticky && (r_instr == 32'd0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FSM_RESET_WAIT: w_state_nxt = FSM_FETCH;
            FSM_FETCH:      if (imem_ack) w_state_nxt = FSM_ISSUE;
            FSM_ISSUE:      if (instr_ready) w_state_nxt = w_zero_halt ? FSM_HALT : FSM_WAIT_NPC;
            FSM_WAIT_NPC:   if (npc_valid) w_state_nxt = (halt_req || r_halt_sticky) ? FSM_HALT : FSM_FETCH;
            FSM_HALT:       w_state_nxt = FSM_HALT;
            default:        w_state_nxt = FSM_RESET_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= FSM_RESET_WAIT;
            r_pc          <= RESET_PC;
            r_instr       <= 32'd0;
            r_instr_pc    <= 30'd0;
            r_instr_valid <= 1'b0;
            r_halt_sticky <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (halt_req) r_halt_sticky <= 1'b1;
            if (w_fetch_ack) begin
                r_instr       <= imem_rdata;
                r_instr_pc    <= r_pc;
                r_instr_valid <= 1'b1;
            end
            if (w_npc_take) begin
                r_pc          <= npc;
                r_instr_valid <= 1'b0;
            end
            if (w_state_nxt == FSM_HALT) r_instr_valid <= 1'b0;
        end
    end

    assign imem_req    = (r_state == FSM_FETCH);
    assign imem_addr   = r_pc;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign halted      = (r_state == FSM_HALT);
    assign pc          = r_pc;

`ifdef PC_FETCH_CTRL_PERF_EN
    pc_perf_counters u_perf (
        .clk         (clk),
        .rst         (rst),
        .retire_inc  (w_npc_take),
        .stall_inc   ((r_state == FSM_FETCH) && !imem_ack),
        .retired_cnt (retired_cnt),
        .stall_cnt   (stall_cnt)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
// ============================================================================
//  Module   : tb_pc_fetch_ctrl
//  Brief    : Directed plus randomized transaction-level bench for pc_fetch_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_ctrl;

    localparam logic [29:0] RST_PC = 30'h0000_0C00;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [29:0] instr_pc;
    logic        npc_valid = 1'b0;
    logic [29:0] npc = 30'd0;
    logic        halt_req = 1'b0;
    logic        halted;
    logic [29:0] pc;
`ifdef PC_FETCH_CTRL_PERF_EN
    logic [31:0] retired_cnt;
    logic [31:0] stall_cnt;
`endif

    pc_fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .npc_valid   (npc_valid),
        .npc         (npc),
        .halt_req    (halt_req),
        .halted      (halted),
        .pc          (pc)
`ifdef PC_FETCH_CTRL_PERF_EN
        ,
        .retired_cnt (retired_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: program counter, pending halt, halted flag, counters
    logic [29:0] m_pc = RST_PC;
    bit          m_sticky = 1'b0;
    bit          m_halted = 1'b0;
    int unsigned m_retired = 0;
    int unsigned m_stall = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_perf();
`ifdef PC_FETCH_CTRL_PERF_EN
        check("retired_cnt", retired_cnt, 32'(m_retired));
        check("stall_cnt", stall_cnt, 32'(m_stall));
`endif
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0; npc_valid = 1'b0; halt_req = 1'b0;
        repeat (cycles) tick();
        m_pc = RST_PC; m_sticky = 1'b0; m_halted = 1'b0; m_retired = 0; m_stall = 0;
        check("rst_pc", 32'(pc), 32'(m_pc));
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", 32'(instr_pc), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check_perf();
        rst = 1'b0;
        tick();
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", 32'(imem_addr), 32'(m_pc));
    endtask

    // One full instruction: fetch (with stalls), issue (with backpressure), next-PC.
    task automatic do_instr(input int ack_delay, input int ready_delay, input int wait_delay,
                            input logic [31:0] word, input logic [29:0] npc_val,
                            input bit halt_fetch, input bit halt_npc);
        logic [29:0] fpc;
        if (m_halted) return;
        fpc = m_pc;
        check("fetch_req", 32'(imem_req), 32'd1);
        check("fetch_addr", 32'(imem_addr), 32'(fpc));
        repeat (ack_delay) begin
            imem_ack = 1'b0; npc_valid = 1'($urandom); npc = 30'($urandom);
            tick();
            m_stall++;
            check("stall_req", 32'(imem_req), 32'd1);
            check("stall_addr", 32'(imem_addr), 32'(fpc));
            check("stall_valid", 32'(instr_valid), 32'd0);
            check("stall_pc", 32'(pc), 32'(fpc));
        end
        imem_ack = 1'b1; imem_rdata = word; halt_req = halt_fetch; npc_valid = 1'b0;
        tick();
        imem_ack = 1'b0; halt_req = 1'b0; imem_rdata = $urandom;
        if (halt_fetch) m_sticky = 1'b1;
        check("issue_valid", 32'(instr_valid), 32'd1);
        check("issue_instr", instr, word);
        check("issue_instr_pc", 32'(instr_pc), 32'(fpc));
        check("issue_req", 32'(imem_req), 32'd0);
        repeat (ready_delay) begin
            instr_ready = 1'b0; npc_valid = 1'b1; npc = 30'($urandom);
            tick();
            check("bp_instr", instr, word);
            check("bp_instr_pc", 32'(instr_pc), 32'(fpc));
            check("bp_valid", 32'(instr_valid), 32'd1);
            check("bp_req", 32'(imem_req), 32'd0);
            check("bp_pc", 32'(pc), 32'(fpc));
        end
        instr_ready = 1'b1; npc_valid = 1'($urandom); npc = 30'($urandom);
        tick();
        instr_ready = 1'b0; npc_valid = 1'b0;
        if (word == 32'd0 && m_sticky) begin
            m_halted = 1'b1;
            check("zhalt_halted", 32'(halted), 32'd1);
            check("zhalt_valid", 32'(instr_valid), 32'd0);
            check("zhalt_pc", 32'(pc), 32'(fpc));
            check("zhalt_req", 32'(imem_req), 32'd0);
            check_perf();
            return;
        end
        check("wait_valid", 32'(instr_valid), 32'd1);
        check("wait_pc", 32'(pc), 32'(fpc));
        repeat (wait_delay) begin
            tick();
            check("wait_hold_valid", 32'(instr_valid), 32'd1);
            check("wait_hold_req", 32'(imem_req), 32'd0);
        end
        npc_valid = 1'b1; npc = npc_val; halt_req = halt_npc;
        tick();
        npc_valid = 1'b0; halt_req = 1'b0;
        m_pc = npc_val;
        m_retired++;
        check("npc_pc", 32'(pc), 32'(m_pc));
        check("npc_valid_clr", 32'(instr_valid), 32'd0);
        if (halt_npc || m_sticky) begin
            m_halted = 1'b1;
            check("halt_halted", 32'(halted), 32'd1);
            check("halt_req", 32'(imem_req), 32'd0);
        end else begin
            check("next_halted", 32'(halted), 32'd0);
            check("next_req", 32'(imem_req), 32'd1);
            check("next_addr", 32'(imem_addr), 32'(m_pc));
        end
        check_perf();
    endtask

    task automatic halted_idle(input int cycles);
        repeat (cycles) begin
            imem_ack = 1'($urandom); npc_valid = 1'($urandom); npc = 30'($urandom);
            instr_ready = 1'($urandom);
            tick();
            check("idle_halted", 32'(halted), 32'd1);
            check("idle_req", 32'(imem_req), 32'd0);
            check("idle_valid", 32'(instr_valid), 32'd0);
            check("idle_pc", 32'(pc), 32'(m_pc));
        end
        imem_ack = 1'b0; npc_valid = 1'b0; instr_ready = 1'b0;
        check_perf();
    endtask

    // Reset lands together with an ack; the ack in the following cycle must be ignored too.
    task automatic reset_mid_fetch();
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        m_pc = RST_PC; m_sticky = 1'b0; m_halted = 1'b0; m_retired = 0; m_stall = 0;
        check("rmf_valid", 32'(instr_valid), 32'd0);
        check("rmf_pc", 32'(pc), 32'(RST_PC));
        check("rmf_req", 32'(imem_req), 32'd0);
        rst = 1'b0;
        tick();
        imem_ack = 1'b0;
        check("rmf_late_ack_valid", 32'(instr_valid), 32'd0);
        check("rmf_late_ack_instr", instr, 32'd0);
        check("rmf_restart_req", 32'(imem_req), 32'd1);
        check("rmf_restart_addr", 32'(imem_addr), 32'(RST_PC));
    endtask

    initial begin
        @(negedge clk);
        // Straight-line code, memory stall, backpressure + branch redirect
        do_reset(2);
        do_instr(0, 0, 0, 32'h0000_1111, 30'h0C01, 1'b0, 1'b0);
        do_instr(4, 0, 0, 32'h0000_2222, 30'h0C02, 1'b0, 1'b0);
        do_instr(0, 3, 2, 32'h0000_3333, 30'h0C10, 1'b0, 1'b0);
        do_instr(0, 0, 0, 32'h0000_4444, 30'h0C11, 1'b0, 1'b0);
        // Halt requested during fetch of 0xC03
        do_reset(2);
        do_instr(0, 0, 0, 32'hA000_0001, 30'h0C01, 1'b0, 1'b0);
        do_instr(0, 0, 0, 32'hA000_0002, 30'h0C02, 1'b0, 1'b0);
        do_instr(0, 0, 0, 32'hA000_0003, 30'h0C03, 1'b0, 1'b0);
        do_instr(1, 0, 0, 32'hA000_0004, 30'h0C04, 1'b1, 1'b0);
        halted_idle(5);
        // Reset mid-fetch with a coincident ack
        do_reset(2);
        do_instr(0, 0, 0, 32'h1234_5678, 30'h0C01, 1'b0, 1'b0);
        reset_mid_fetch();
        // Zero word after halt request halts straight from issue
        do_instr(1, 1, 0, 32'h0000_0000, 30'h0C01, 1'b1, 1'b0);
        halted_idle(3);
        // Address wrap-around
        do_reset(1);
        do_instr(0, 0, 0, 32'h0BAD_0001, 30'h3FFF_FFFF, 1'b0, 1'b0);
        do_instr(0, 0, 0, 32'h0BAD_0002, 30'h0000_0000, 1'b0, 1'b0);
        do_instr(0, 0, 0, 32'h0BAD_0003, 30'h0000_0001, 1'b0, 1'b0);
        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            if (m_halted) begin
                halted_idle(2);
                do_reset(1 + int'($urandom_range(0, 1)));
            end else if ($urandom_range(0, 29) == 0) begin
                reset_mid_fetch();
            end else begin
                do_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 2)),
                         ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
                         ($urandom_range(0, 3) == 0) ? 30'($urandom) : 30'(m_pc + 30'd1),
                         ($urandom_range(0, 19) == 0), ($urandom_range(0, 24) == 0));
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
